// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg
// Shared definitions for the truth table checker slice:
//   state_t   - capture FSM states (IDLE, CAPTURE, DONE)
//   MISR_POLY - feedback polynomial of the optional response signature
//   MISR_SEED - value the signature is loaded with on every start pulse
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/truth_table_checker_misr16.sv
// misr16
// 16-bit multiple-input signature register that compresses the stream of
// accepted (vector, response) samples into one word.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, clears sig to 0
//   clear in   loads the seed value (wins over en)
//   en    in   fold din into the signature this cycle
//   din   in   16-bit sample word
//   sig   out  current signature
module misr16
    import truth_table_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sig
);

    // Shift left with polynomial feedback from the MSB, then XOR in the sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= 16'h0000;
        end else if (clear) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker
// Receive end of the vector sweep flow: captures (input vector, observed
// output) samples of a 4-input unit, builds its truth table, tracks coverage,
// counts mismatches against a golden table and reports done/pass once every
// vector has been seen.
// Optional feature: define TRUTH_TABLE_CHECKER_MISR_EN to build a 16-bit MISR
// over all accepted samples; otherwise signature is tied to zero.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   pulse: clear and begin a new capture
//   s_valid      in   sample valid
//   s_ready      out  block accepts a sample (CAPTURE only)
//   s_vec        in   input vector of the sample
//   s_f          in   observed output at s_vec
//   done         out  all vectors captured, held until next start
//   pass         out  done with zero mismatches and no duplicate
//   mismatch_cnt out  first-sample mismatches, saturating at D
//   dup_err      out  sticky: a vector arrived twice in one capture
//   table_q      out  captured truth table
//   cov          out  coverage mask
//   signature    out  MISR signature (0 when the MISR is not built)
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                    N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = 16'h0100
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N_IN-1:0]         s_vec,
    input  logic                    s_f,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           mismatch_cnt,
    output logic                    dup_err,
    output logic [(1<<N_IN)-1:0]    table_q,
    output logic [(1<<N_IN)-1:0]    cov,
    output logic [15:0]             signature
);

    localparam int D = 1 << N_IN;
    localparam logic [N_IN:0] CNT_MAX = {1'b1, {N_IN{1'b0}}};

    state_t         state;
    state_t         state_next;
    logic           hs;
    logic           new_vec;
    logic           complete;
    logic [D-1:0]   vec_bit;

    assign hs       = s_valid && (state == CAPTURE);
    assign new_vec  = hs && !cov[s_vec];

    always_comb begin
        vec_bit        = '0;
        vec_bit[s_vec] = 1'b1;
    end

    // The capture is complete when this first-time sample fills the last hole.
    assign complete = new_vec && (&(cov | vec_bit));

    // Status outputs decode straight from registers only.
    assign s_ready = (state == CAPTURE);
    assign done    = (state == DONE);
    assign pass    = (state == DONE) && (mismatch_cnt == '0) && !dup_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start in CAPTURE restarts the capture, so it overrides completion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CAPTURE;
            CAPTURE: if (!start && complete) state_next = DONE;
            DONE:    if (start) state_next = CAPTURE;
            default: state_next = IDLE;
        endcase
    end

    // Start clears in every state; a handshake in the same cycle is dropped.
    // A repeated vector only raises dup_err, keeping the first response.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            table_q      <= '0;
            cov          <= '0;
            mismatch_cnt <= '0;
            dup_err      <= 1'b0;
        end else if (hs) begin
            if (!cov[s_vec]) begin
                table_q[s_vec] <= s_f;
                cov[s_vec]     <= 1'b1;
                if ((s_f != EXPECTED[s_vec]) && (mismatch_cnt != CNT_MAX)) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
            end else begin
                dup_err <= 1'b1;
            end
        end
    end

`ifdef TRUTH_TABLE_CHECKER_MISR_EN
    logic [15:0] misr_din;

    always_comb begin
        misr_din         = '0;
        misr_din[N_IN:0] = {s_vec, s_f};
    end

    misr16 u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .en    (hs),
        .din   (misr_din),
        .sig   (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule
